// File: rtl/imem_pkg.sv
// Shared types and constants for the dual-core instruction-fetch arbiter.
package imem_pkg;

    localparam int unsigned ROM_WORDS_DEF = 64;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic {
        PRIO0 = 1'b0,
        PRIO1 = 1'b1
    } prio_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } fetch_rsp_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The favoured core flips to the loser after
// every grant, so continuous contention alternates 0,1,0,1.
module rr_arbiter2
    import imem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    prio_e prio_q;
    prio_e prio_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= PRIO0;
        end else begin
            prio_q <= prio_d;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt[0]) begin
            prio_d = PRIO1;
        end else if (gnt[1]) begin
            prio_d = PRIO0;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (prio_q == PRIO0) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one combinational instruction-ROM port between two cores; grants
// round-robin, range-checks the address and registers the word back.
module imem_fetch_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned ROM_WORDS = ROM_WORDS_DEF,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c0_req,
    input  logic [31:0]      c0_addr,
    output logic             c0_gnt,
    output logic             c0_rvalid,
    output logic [31:0]      c0_rdata,
    output logic             c0_err,
    input  logic             c1_req,
    input  logic [31:0]      c1_addr,
    output logic             c1_gnt,
    output logic             c1_rvalid,
    output logic [31:0]      c1_rdata,
    output logic             c1_err,
    output logic [31:0]      rom_addr,
    input  logic [31:0]      rom_rdata,
    output logic [CNT_W-1:0] c0_fetch_cnt,
    output logic [CNT_W-1:0] c1_fetch_cnt
);

    function automatic logic range_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(ROM_WORDS));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [1:0]       gnt;
    logic [31:0]      sel_addr;
    logic             fetch_err;
    fetch_rsp_t       rsp_p0;
    fetch_rsp_t       rsp0_p1;
    fetch_rsp_t       rsp1_p1;
    logic [CNT_W-1:0] cnt0_p1;
    logic [CNT_W-1:0] cnt1_p1;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   ({c1_req, c0_req}),
        .gnt   (gnt)
    );

    // Stage p0: grant, ROM address and range check, all combinational
    always_comb begin
        sel_addr     = gnt[1] ? c1_addr : c0_addr;
        rom_addr     = (|gnt) ? sel_addr : 32'h0;
        fetch_err    = range_err(sel_addr);
        rsp_p0.valid = 1'b1;
        rsp_p0.err   = fetch_err;
        rsp_p0.data  = fetch_err ? NOP_INSTR : rom_rdata;
    end

    // Stage p1: response registers and saturating grant counters
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp0_p1 <= '0;
            rsp1_p1 <= '0;
            cnt0_p1 <= '0;
            cnt1_p1 <= '0;
        end else begin
            if (gnt[0]) begin
                rsp0_p1 <= rsp_p0;
                cnt0_p1 <= sat_inc(cnt0_p1);
            end else begin
                rsp0_p1.valid <= 1'b0;
            end
            if (gnt[1]) begin
                rsp1_p1 <= rsp_p0;
                cnt1_p1 <= sat_inc(cnt1_p1);
            end else begin
                rsp1_p1.valid <= 1'b0;
            end
        end
    end

    assign c0_gnt       = gnt[0];
    assign c1_gnt       = gnt[1];
    assign c0_rvalid    = rsp0_p1.valid;
    assign c0_err       = rsp0_p1.err;
    assign c0_rdata     = rsp0_p1.data;
    assign c1_rvalid    = rsp1_p1.valid;
    assign c1_err       = rsp1_p1.err;
    assign c1_rdata     = rsp1_p1.data;
    assign c0_fetch_cnt = cnt0_p1;
    assign c1_fetch_cnt = cnt1_p1;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed plus randomized bench for imem_fetch_arbiter against a
// cycle-level behavioural model of the arbitration and fetch rules.
module tb_imem_fetch_arbiter;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int WORDS   = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             c0_req, c1_req;
    logic [31:0]      c0_addr, c1_addr;
    logic             c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_err, c1_err;
    logic [31:0]      c0_rdata, c1_rdata, rom_addr, rom_rdata;
    logic [CNT_W-1:0] c0_fetch_cnt, c1_fetch_cnt;

    logic [31:0] rom [WORDS];
    assign rom_rdata = rom[rom_addr[7:2]];

    always #5 clk = ~clk;

    imem_fetch_arbiter #(.ROM_WORDS(WORDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_addr(c0_addr), .c0_gnt(c0_gnt),
        .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata), .c0_err(c0_err),
        .c1_req(c1_req), .c1_addr(c1_addr), .c1_gnt(c1_gnt),
        .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata), .c1_err(c1_err),
        .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .c0_fetch_cnt(c0_fetch_cnt), .c1_fetch_cnt(c1_fetch_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int          m_prio;
    int          m_cnt   [2];
    logic [31:0] m_data  [2];
    logic        m_err   [2];
    logic        m_valid [2];
    int          last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= WORDS);
    endfunction

    task automatic step(input logic r0, input logic [31:0] a0,
                        input logic r1, input logic [31:0] a1, input logic rs);
        int          g;
        logic [31:0] ga;
        logic        bad;
        reset = rs; c0_req = r0; c0_addr = a0; c1_req = r1; c1_addr = a1;
        #1;
        g = -1;
        if (!rs) begin
            if (r0 && r1)  g = m_prio;
            else if (r0)   g = 0;
            else if (r1)   g = 1;
        end
        ga = (g == 0) ? a0 : (g == 1) ? a1 : 32'h0;
        chk("c0_gnt", c0_gnt, g == 0);
        chk("c1_gnt", c1_gnt, g == 1);
        chk("rom_addr", rom_addr, ga);

        @(posedge clk);
        #1;
        if (rs) begin
            m_prio = 0;
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_data[i] = 32'h0; m_err[i] = 1'b0; m_valid[i] = 1'b0;
            end
        end else begin
            m_valid[0] = (g == 0);
            m_valid[1] = (g == 1);
            if (g >= 0) begin
                bad       = addr_bad(ga);
                m_err[g]  = bad;
                m_data[g] = bad ? 32'h0 : rom[ga / 4];
                if (m_cnt[g] < CNT_MAX) m_cnt[g]++;
                m_prio = 1 - g;
            end
        end
        last_g = g;
        chk("c0_rvalid", c0_rvalid, m_valid[0]);
        chk("c1_rvalid", c1_rvalid, m_valid[1]);
        chk("c0_rdata", c0_rdata, m_data[0]);
        chk("c1_rdata", c1_rdata, m_data[1]);
        chk("c0_err", c0_err, m_err[0]);
        chk("c1_err", c1_err, m_err[1]);
        chk("c0_fetch_cnt", c0_fetch_cnt, m_cnt[0]);
        chk("c1_fetch_cnt", c1_fetch_cnt, m_cnt[1]);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return {24'h0, 6'($urandom_range(0, WORDS - 1)), 2'b00};
            2:       return {24'h0, 6'($urandom_range(0, WORDS - 1)), 2'($urandom_range(1, 3))};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        p0, p1;
        logic [31:0] pa0, pa1;

        for (int i = 0; i < WORDS; i++) rom[i] = $urandom | 32'h0000_0100;
        rom[0] = 32'h2008_0001;
        m_prio = 0;
        last_g = -1;

        // Reset held with both cores requesting: no grants
        step(1'b1, 32'h0, 1'b1, 32'h4, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rst_c0_rdata", c0_rdata, 32'h0);
        chk("rst_cnt0", c0_fetch_cnt, 0);

        // Single core-0 fetch of ROM[0]
        step(1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("first_fetch_data", c0_rdata, 32'h2008_0001);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Core 1 alone, then six cycles of contention
        step(1'b0, 32'h0, 1'b1, 32'h8, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 32'h4, 1'b1, 32'h8, 1'b0);

        // Out-of-range and misaligned fetches by core 1
        step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
        chk("oor_err", c1_err, 1'b1);
        step(1'b0, 32'h0, 1'b1, 32'h6, 1'b0);
        chk("misalign_data", c1_rdata, 32'h0);

        // Core 1 alone, then dual request must go to core 0
        step(1'b0, 32'h0, 1'b1, 32'hC, 1'b0);
        step(1'b1, 32'h10, 1'b1, 32'h14, 1'b0);
        chk("prio_flip_gnt", last_g, 0);

        // Grant to core 0, reset next cycle, then dual request after release
        step(1'b1, 32'h18, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h1C, 1'b1, 32'h20, 1'b1);
        step(1'b1, 32'h1C, 1'b1, 32'h20, 1'b0);
        chk("post_reset_gnt", last_g, 0);

        // Counter saturation
        for (int i = 0; i < 20; i++) step(1'b1, 32'(4 * (i % WORDS)), 1'b0, 32'h0, 1'b0);
        chk("c0_cnt_sat", c0_fetch_cnt, 15);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic honouring the hold-until-grant protocol
        p0 = 1'b0; p1 = 1'b0; pa0 = 32'h0; pa1 = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic rs;
            if (!p0 && $urandom_range(0, 9) < 6) begin p0 = 1'b1; pa0 = rand_addr(); end
            if (!p1 && $urandom_range(0, 9) < 6) begin p1 = 1'b1; pa1 = rand_addr(); end
            rs = ($urandom_range(0, 49) == 0);
            step(p0, pa0, p1, pa1, rs);
            if (last_g == 0) p0 = 1'b0;
            if (last_g == 1) p1 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Shares the single combinational instruction-ROM read port between the two cores of the dual-core processor. Each core issues fetch requests with a byte address; the block grants one core per cycle with round-robin priority, drives the ROM address, and registers the returned instruction word back to the granted core one cycle later. Out-of-range or misaligned fetches return a NOP and an error flag instead of aliasing into the ROM.

## Interface
- `ROM_WORDS`, default 64: ROM depth in 32-bit words; must be a power of two.
- `CNT_W`, default 16: width of the per-core saturating grant counters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `c0_req`  in  1  core 0 fetch request; held until `c0_gnt`.
- `c0_addr`  in  32  core 0 byte address; stable while `c0_req` is high.
- `c0_gnt`  out  1  core 0 request accepted this cycle (combinational).
- `c0_rvalid`  out  1  `c0_rdata` valid (registered).
- `c0_rdata`  out  32  instruction word for core 0.
- `c0_err`  out  1  qualifies `c0_rvalid`: fetch was out of range or misaligned.
- `c1_req`, `c1_addr`, `c1_gnt`, `c1_rvalid`, `c1_rdata`, `c1_err`: same as core 0, for core 1.
- `rom_addr`  out  32  byte address to the instruction ROM.
- `rom_rdata`  in  32  combinational ROM read data.
- `c0_fetch_cnt`, `c1_fetch_cnt`  out  CNT_W  grants issued per core, saturating.

## Operation
- Priority register `prio` is 1 bit; 0 means core 0 is favoured. Reset value is 0.
- Grant rules:
  - Only one requester: it is granted.
  - Both request: core `prio` is granted.
  - Neither requests: no grant, and `rom_addr` = 0.
- After any grant, `prio` becomes the index of the core that was not granted. Two continuously requesting cores therefore alternate 0,1,0,1.
- `rom_addr` equals the granted core's address.
- Range check on the granted address:
  - `addr[1:0] != 0` is an error.
  - `addr >> 2 >= ROM_WORDS` is an error.
- Response register, loaded each cycle:
  - `rvalid` is set only for the granted core.
  - `rdata` = `rom_rdata`, or 32'h0000_0000 (NOP) on error.
  - `err` is set to the error result.
- On a cycle with no grant, both `rvalid` outputs clear. `rdata` holds its previous value.
- Fetch counters increment on each grant and saturate at all-ones. They never wrap.
- State is `prio`, the two response registers and the two counters. No other FSM is needed: the arbiter is a two-state round-robin (`PRIO0`/`PRIO1`). The transition happens only on a grant, and only to the other core's state.

## Timing
- Grant is combinational, in the same cycle as the request.
- Data latency is 1 cycle: `cN_rvalid` is high on the cycle after `cN_gnt`, for exactly one cycle.
- Throughput is one fetch per cycle in aggregate. A lone requester is granted every cycle. Each core gets 1 of 2 cycles under contention.
- A core must not change `cN_addr` while `cN_req` is high and ungranted. A core may present a new request in the cycle after its grant.
- Reset (sync, high), applied at any time:
  - Next edge: `prio`=0, all `rvalid`=0, `err`=0, `rdata`=0, counters=0.
  - An in-flight response in the register is discarded.
  - Grants are suppressed while `reset` is high.
- Simultaneous request from both cores on the first cycle after reset: core 0 is granted.

## Structure
- Shared package `imem_pkg` holds:
  - `NOP_INSTR` = 32'h0000_0000.
  - Default `ROM_WORDS`.
  - A `fetch_rsp_t` struct {valid, err, data}.
- One natural sub-module, `rr_arbiter2`: 2-input round-robin arbiter with `prio` register, request inputs and one-hot grant output. Range check and response registers stay in the top.

## Test plan
- Reset, then `c0_req`=1 with `c0_addr`=0x0 and ROM[0]=0x2008_0001 → `c0_gnt`=1 at once. Next cycle: `c0_rvalid`=1, `c0_rdata`=0x2008_0001, `c0_err`=0, `c0_fetch_cnt`=1.
- Both cores request continuously for 6 cycles, addresses 0x4 and 0x8 → grants go 0,1,0,1,0,1. Responses are ROM[1] and ROM[2] alternately, one cycle late. Both counters end at 3.
- `c1_addr`=0x100 (word 64), then 0x6 (misaligned) → `c1_gnt`=1 both times. Responses: `c1_rvalid`=1, `c1_err`=1, `c1_rdata`=0x0 both times, and ROM content is not returned.
- Core 1 granted alone, then both request the next cycle → core 0 is granted, because `prio` flipped to 0 after core 1's grant.
- Grant to core 0, then assert `reset` in the following cycle → `c0_rvalid`=0 after the edge, counters=0. A first dual request after release grants core 0.
- Preload `c0_fetch_cnt` near max via `CNT_W`=4 and 20 core-0 grants → counter stops at 15.
